// File: rtl/seq_mult_arb_pkg.sv
// seq_mult_arb_pkg: shared FSM state encoding and default sizing for seq_mult_arbiter
package seq_mult_arb_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_MULT_CYCLES = 8;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/seq_mult_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after prio_ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     prio_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id
);
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % NUM_REQ);
  endfunction
  // scan from farthest to nearest offset so the nearest requester to prio_ptr wins
  always_comb begin
    grant = '0;
    grant_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(prio_ptr, k)]) begin
        grant = '0;
        grant[wrap_idx(prio_ptr, k)] = 1'b1;
        grant_id = wrap_idx(prio_ptr, k);
      end
    end
  end
endmodule

// File: rtl/seq_mult_arbiter.sv
// seq_mult_arbiter: round-robin sharing of one sequential multiplier; optional SEQ_MULT_ARB_ZERO_SKIP_EN bypasses zero operands
module seq_mult_arbiter
  import seq_mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [2*WIDTH-1:0]       rsp_c,
  output logic                     mult_enable,
  output logic [WIDTH-1:0]         mult_a,
  output logic [WIDTH-1:0]         mult_b,
  input  logic [2*WIDTH-1:0]       mult_c
);
  localparam int CW = $clog2(MULT_CYCLES + 1);
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_id;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_c;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_gid;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_fire;
  logic               w_last;
  // only offer requests to the arbiter while idle and out of reset
  assign w_req = (r_state == S_IDLE && !reset) ? req_valid : '0;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (w_req),
    .prio_ptr (r_ptr),
    .grant    (w_grant),
    .grant_id (w_gid)
  );
  assign w_fire = |w_grant;
  assign w_a = req_a[w_gid*WIDTH +: WIDTH];
  assign w_b = req_b[w_gid*WIDTH +: WIDTH];
  assign w_last = (r_cnt == CW'(MULT_CYCLES - 1));
  assign req_ready = w_grant;
  assign mult_enable = (r_state == S_RUN);
  assign rsp_valid = (r_state == S_RESP);
  assign mult_a = r_a;
  assign mult_b = r_b;
  assign rsp_c = r_c;
  assign rsp_id = r_id;
  // control FSM: accept, run the multiplier for MULT_CYCLES, hold the product until taken
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_ptr <= '0;
      r_id <= '0;
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_a <= w_a;
            r_b <= w_b;
            r_id <= w_gid;
            r_cnt <= '0;
`ifdef SEQ_MULT_ARB_ZERO_SKIP_EN
            if (w_a == '0 || w_b == '0) begin
              r_c <= '0;
              r_state <= S_RESP;
            end else begin
              r_state <= S_RUN;
            end
`else
            r_state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_c <= mult_c;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_ptr <= (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult_arbiter.sv
// tb_seq_mult_arbiter: directed vectors plus corner sequences against a shift-add multiplier model
module tb_seq_mult_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_c;
  logic        mult_enable;
  logic [7:0]  mult_a;
  logic [7:0]  mult_b;
  logic [15:0] mult_c;
  int          n_total = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [3:0]  mk = '0;

  seq_mult_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c), .mult_enable(mult_enable),
    .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // multiplier model: one partial product per enabled cycle, final after 8 enabled cycles
  always @(posedge clk) mk <= mult_enable ? mk + 4'd1 : 4'd0;
  always_comb begin
    mult_c = 16'hDEAD;
    if (mult_enable) begin
      mult_c = '0;
      for (int i = 0; i < 8; i++)
        if (i <= int'(mk) && mult_b[i]) mult_c = mult_c + ({8'd0, mult_a} << i);
    end
  end

  typedef struct {
    int          port;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_rsp(input string nm);
    int n = 0;
    while (!rsp_valid && n < 30) begin
      tick();
      n++;
    end
    chk({nm, "_rsp_seen"}, rsp_valid, 1);
  endtask

  task automatic complete;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
  endtask

  task automatic set_ops(input int p, input logic [7:0] a, input logic [7:0] b);
    req_a[p*8 +: 8] = a;
    req_b[p*8 +: 8] = b;
  endtask

  task automatic do_op(input vec_t v);
    int lat = 0;
    int en = 0;
    int exp_lat = 9;
    int exp_en = 8;
    bit stable = 1'b1;
`ifdef SEQ_MULT_ARB_ZERO_SKIP_EN
    if (v.a == 0 || v.b == 0) begin
      exp_lat = 1;
      exp_en = 0;
    end
`endif
    set_ops(v.port, v.a, v.b);
    req_valid = 4'(1 << v.port);
    #1;
    chk("vec_req_ready", req_ready, 1 << v.port);
    do begin
      tick();
      lat++;
      if (lat == 1) req_valid = '0;
      if (mult_enable) begin
        en++;
        if (mult_a !== v.a || mult_b !== v.b) stable = 1'b0;
      end
    end while (!rsp_valid && lat < 20);
    chk("vec_latency", lat, exp_lat);
    chk("vec_enable_cycles", en, exp_en);
    chk("vec_operands_stable", stable, 1);
    chk("vec_rsp_c", rsp_c, v.c);
    chk("vec_rsp_id", rsp_id, v.port);
    complete();
    chk("vec_back_idle", rsp_valid, 0);
  endtask

  initial begin
    int last;
    int n;
    vecs[0] = '{0, 8'd239, 8'd163, 16'd38957};
    vecs[1] = '{1, 8'd255, 8'd255, 16'd65025};
    vecs[2] = '{2, 8'd255, 8'd1,   16'd255};
    vecs[3] = '{3, 8'd0,   8'd200, 16'd0};
    vecs[4] = '{2, 8'd12,  8'd13,  16'd156};
    vecs[5] = '{0, 8'd200, 8'd0,   16'd0};

    do_reset();
    chk("rst_mult_enable", mult_enable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_rsp_c", rsp_c, 0);
    chk("rst_rsp_id", rsp_id, 0);

    for (int i = 0; i < 6; i++) do_op(vecs[i]);

    // round robin with all ports requesting and the consumer always ready
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 1), 8'd10);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (req_ready == 0 && n < 30) begin
        tick();
        n++;
      end
      chk("rr_grant", req_ready, 1 << (k % 4));
      if (k > 0) chk("rr_period", cyc - last, 10);
      last = cyc;
      tick();
      wait_rsp("rr");
      chk("rr_rsp_id", rsp_id, k % 4);
      chk("rr_rsp_c", rsp_c, ((k % 4) + 1) * 10);
      chk("rr_enable_low_in_resp", mult_enable, 0);
      chk("rr_no_ready_in_resp", req_ready, 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();

    // backpressure: product held while another port waits
    set_ops(1, 8'd7, 8'd9);
    req_valid = 4'b0010;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0100;
    set_ops(2, 8'd3, 8'd3);
    wait_rsp("bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_c_held", rsp_c, 63);
      chk("bp_rsp_id_held", rsp_id, 1);
      chk("bp_req_ready_low", req_ready, 0);
      tick();
    end
    chk("bp_still_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("bp_completed", rsp_valid, 0);
    chk("bp_next_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    wait_rsp("bp2");
    chk("bp2_rsp_c", rsp_c, 9);
    chk("bp2_rsp_id", rsp_id, 2);
    complete();

    // reset in the 4th RUN cycle drops the operation and the pointer
    do_op('{1, 8'd5, 8'd5, 16'd25});
    set_ops(2, 8'd11, 8'd11);
    req_valid = 4'b0100;
    #1;
    chk("mr_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    chk("mr_in_run", mult_enable, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mr_mult_enable", mult_enable, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_mult_a", mult_a, 0);
    chk("mr_mult_b", mult_b, 0);
    chk("mr_rsp_c", rsp_c, 0);
    chk("mr_rsp_id", rsp_id, 0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid) n++;
      tick();
    end
    chk("mr_no_response", n, 0);
    set_ops(0, 8'd2, 8'd3);
    set_ops(3, 8'd4, 8'd5);
    req_valid = 4'b1001;
    #1;
    chk("mr_grant_from_0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1000;
    wait_rsp("mr");
    chk("mr_rsp_c", rsp_c, 6);
    complete();
    chk("mr_then_port3", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    wait_rsp("mr3");
    chk("mr3_rsp_c", rsp_c, 20);
    complete();

    // wrap-around: after port 2 the pointer is 3, so 3 beats 1
    do_op('{2, 8'd6, 8'd6, 16'd36});
    set_ops(1, 8'd8, 8'd8);
    set_ops(3, 8'd9, 8'd9);
    req_valid = 4'b1010;
    #1;
    chk("wrap_first", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0010;
    wait_rsp("wrap");
    chk("wrap_first_id", rsp_id, 3);
    chk("wrap_first_c", rsp_c, 81);
    complete();
    chk("wrap_second", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_rsp("wrap2");
    chk("wrap_second_id", rsp_id, 1);
    chk("wrap_second_c", rsp_c, 64);
    complete();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/seq_mult_arbiter.md
# seq_mult_arbiter

Round-robin controller that shares one sequential 8×8 shift-add multiplier (ports `enable`, `A`, `B`, `C`) among several requesters. It accepts one operand pair at a time, drives the multiplier's `enable` for a fixed number of cycles, captures the 16-bit product and returns it tagged with the requester index. It sits between the requester ports and the single multiplier instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand width; product is `2*WIDTH`.
- `MULT_CYCLES`, 8: cycles `enable` must stay high before the multiplier's `C` is final.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester request.
- `req_ready` out NUM_REQ: one-hot accept; at most one bit high.
- `req_a` in NUM_REQ*WIDTH: packed operand A, requester i at bits [i*WIDTH +: WIDTH].
- `req_b` in NUM_REQ*WIDTH: packed operand B, same packing.
- `rsp_valid` out 1: product available.
- `rsp_ready` in 1: consumer accepts product.
- `rsp_id` out $clog2(NUM_REQ): index of the requester that owns `rsp_c`.
- `rsp_c` out 2*WIDTH: product.
- `mult_enable` out 1: to multiplier `enable`.
- `mult_a`, `mult_b` out WIDTH: to multiplier `A`, `B`.
- `mult_c` in 2*WIDTH: from multiplier `C`.

## Operation
- States: IDLE, RUN, RESP.
- IDLE: the arbiter selects the first requester with `req_valid` set, starting at `prio_ptr` and wrapping modulo NUM_REQ. `req_ready[winner]` is high in the same cycle and is combinational from `req_valid`.
  - On handshake: latch `req_a`/`req_b` into `mult_a`/`mult_b`, latch the winner into `rsp_id`, clear the counter, go to RUN.
  - With no request pending, stay in IDLE.
- RUN: `mult_enable`=1. `mult_a`/`mult_b` are held stable. The counter increments each cycle.
  - When the counter reaches MULT_CYCLES-1: register `mult_c` into `rsp_c` and go to RESP.
- RESP: `mult_enable`=0 and `rsp_valid`=1.
  - `rsp_c` and `rsp_id` are held until `rsp_ready`.
  - On `rsp_ready`: set `prio_ptr` = `rsp_id`+1 (wrapping), go to IDLE.
- `req_ready` is 0 in RUN and RESP.
- Requesters keep `req_valid` and operands stable until accepted. Withdrawing a request before acceptance is a protocol violation.
- Product is the unsigned `A*B`, full 2*WIDTH bits, no truncation.
- Reset (any state, including mid-RUN):
  - State = IDLE; the in-flight operation is dropped with no response.
  - `mult_enable`, `rsp_valid`, `req_ready` = 0.
  - `mult_a`, `mult_b`, `rsp_c`, `rsp_id`, `prio_ptr`, counter = 0.

## Timing
- Accept in cycle t. `mult_enable` is high in cycles t+1 … t+MULT_CYCLES. `rsp_valid` rises at t+MULT_CYCLES+1.
- `mult_enable` is low for at least one cycle between operations; this guarantees the multiplier restarts.
- `rsp_ready` high in the first RESP cycle gives the maximum throughput of one product per MULT_CYCLES+2 cycles.
- `rsp_ready` together with a pending request: the response completes that cycle; the new request is accepted no earlier than the next cycle, in IDLE.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 operations.

## Configuration
- `SEQ_MULT_ARB_ZERO_SKIP_EN` defined: if the accepted `req_a` or `req_b` is 0, go IDLE→RESP directly with `rsp_c`=0.
  - `mult_enable` stays low.
  - `rsp_valid` rises at t+1.
- Undefined: every operation passes through RUN for MULT_CYCLES cycles, including zero operands.

## Structure
- Package `seq_mult_arb_pkg`: state enum (IDLE, RUN, RESP) and default constants for WIDTH and MULT_CYCLES.
- Sub-module `rr_arbiter`, purely combinational:
  - Inputs: `req` vector and `prio_ptr`.
  - Outputs: one-hot `grant` and encoded `grant_id`.
- The top holds the FSM, counter, operand/result registers and pointer update.

## Test plan
- Single request: port 0 sends A=239, B=163 → `mult_a`/`mult_b` = 239/163 for 8 cycles. `rsp_valid` at accept+9 with `rsp_c`=38957 and `rsp_id`=0.
- All four ports valid continuously, `rsp_ready`=1 → grants in order 0,1,2,3,0. One response every 10 cycles. `mult_enable` is low for at least 1 cycle between runs.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_c`/`rsp_id` are stable and `req_ready` stays 0. Completion happens on the first `rsp_ready`.
- Boundaries, checked for each of 255×255, 255×1 and 0×200:
  - 255×255 → `rsp_c`=65025.
  - 255×1 → `rsp_c`=255.
  - 0×200 → `rsp_c`=0; with `SEQ_MULT_ARB_ZERO_SKIP_EN` defined, `rsp_valid` at accept+1 and `mult_enable` never high.
- Reset asserted during cycle 4 of RUN → next cycle: IDLE, all outputs 0. No `rsp_valid` for the dropped request. The next request is granted starting from port 0.
- Wrap-around: `prio_ptr`=3 after serving port 2, ports 1 and 3 valid → port 3 is granted first, then port 1.
